// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the life-array pattern loader:
//   TILE_W / POS_W   default tile width and tile-position bus width
//   PRESET_*         tile patterns selectable from the selector switches
//   state_t          loader FSM states
//   decode_preset    selector -> preset, bit0 has the highest priority
//   rotl_nibbles     rotate a tile left by 4*(k mod 4) bits
// ---------------------------------------------------------------------------
package life_pkg;

    localparam int TILE_W = 16;
    localparam int POS_W  = 2;

    localparam logic [TILE_W-1:0] PRESET_0    = 16'h3300;
    localparam logic [TILE_W-1:0] PRESET_1    = 16'h33CC;
    localparam logic [TILE_W-1:0] PRESET_2    = 16'h0700;
    localparam logic [TILE_W-1:0] PRESET_3    = 16'h6186;
    localparam logic [TILE_W-1:0] PRESET_NONE = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic [TILE_W-1:0] decode_preset(input logic [3:0] sel);
        logic [TILE_W-1:0] pat;
        if (sel[0])      pat = PRESET_0;
        else if (sel[1]) pat = PRESET_1;
        else if (sel[2]) pat = PRESET_2;
        else if (sel[3]) pat = PRESET_3;
        else             pat = PRESET_NONE;
        return pat;
    endfunction

    // Rotating a doubled copy and taking the upper half avoids a shift by
    // the full tile width when k mod 4 is zero.
    function automatic logic [TILE_W-1:0] rotl_nibbles(input logic [TILE_W-1:0] p,
                                                       input logic [31:0]       k);
        logic [2*TILE_W-1:0] dbl;
        dbl = {p, p} << (4 * (k % 4));
        return dbl[2*TILE_W-1 -: TILE_W];
    endfunction

endpackage

// File: rtl/life_debounce.sv
// ---------------------------------------------------------------------------
// life_debounce
// Two-flop synchroniser plus counting debouncer for a bouncing push-button.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive synced
// samples disagree with it; any agreeing sample restarts the count.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   din    raw button input, asynchronous to clk
//   level  debounced button level
//   rise   one-cycle pulse, high on the cycle level goes 0 -> 1
// ---------------------------------------------------------------------------
module life_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync_meta_q <= din;
            sync_q      <= sync_meta_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/life_pattern_loader.sv
// ---------------------------------------------------------------------------
// life_pattern_loader
// On a debounced load-button press, latches the preset picked by the
// selector switches and writes it into every tile position of block memory
// through the shared write port, using a req/grant handshake.
// Optional build macro: LIFE_LOADER_ROTATE_EN -- tile k receives the
// pattern rotated left by 4*(k mod 4) bits instead of the plain pattern.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   selector[3:0]      preset switches (asynchronous)
//   load_btn           load push-button (asynchronous, bouncing)
//   mem_grant          write port granted by the generation controller
//   mem_req            write port request
//   mem_write_enb      one-cycle write strobe per tile
//   mem_pos, mem_data  tile position / value of the current write
//   busy               high from press acceptance until done
//   done               one-cycle pulse after the last tile is written
// All outputs are registered.
// ---------------------------------------------------------------------------
module life_pattern_loader #(
    parameter int NUM_TILES       = 4,
    parameter int POS_W           = life_pkg::POS_W,
    parameter int TILE_W          = life_pkg::TILE_W,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        selector,
    input  logic              load_btn,
    input  logic              mem_grant,
    output logic              mem_req,
    output logic              mem_write_enb,
    output logic [POS_W-1:0]  mem_pos,
    output logic [TILE_W-1:0] mem_data,
    output logic              busy,
    output logic              done
);

    import life_pkg::*;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_TILES - 1);

    logic [3:0]        sel_meta_q, sel_sync_q;
    logic              btn_level, btn_rise;
    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [TILE_W-1:0] pattern_q, pattern_d;
    logic              mem_req_q, mem_req_d;
    logic              we_q, we_d;
    logic [POS_W-1:0]  mem_pos_q, mem_pos_d;
    logic [TILE_W-1:0] mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TILE_W-1:0] tile_value;

    life_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (load_btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

`ifdef LIFE_LOADER_ROTATE_EN
    assign tile_value = rotl_nibbles(pattern_q, 32'(pos_q));
`else
    assign tile_value = pattern_q;
`endif

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        pattern_d  = pattern_q;
        mem_req_d  = 1'b0;
        we_d       = 1'b0;
        mem_pos_d  = '0;
        mem_data_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Presses are only looked at here, so a press while busy
                // never touches the latched pattern.
                if (btn_rise && btn_level) begin
                    state_d   = ST_REQ;
                    pos_d     = '0;
                    pattern_d = decode_preset(sel_sync_q);
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_REQ: begin
                mem_req_d = 1'b1;
                busy_d    = 1'b1;
                if (mem_grant) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_req_d = 1'b1;
                busy_d    = 1'b1;
                // Without grant the position simply holds until it returns.
                if (mem_grant) begin
                    we_d       = 1'b1;
                    mem_pos_d  = pos_q;
                    mem_data_d = tile_value;
                    if (pos_q == POS_LAST) begin
                        pos_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // busy stays up alongside the done pulse and drops after it.
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_meta_q <= '0;
            sel_sync_q <= '0;
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            pattern_q  <= '0;
            mem_req_q  <= 1'b0;
            we_q       <= 1'b0;
            mem_pos_q  <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sel_meta_q <= selector;
            sel_sync_q <= sel_meta_q;
            state_q    <= state_d;
            pos_q      <= pos_d;
            pattern_q  <= pattern_d;
            mem_req_q  <= mem_req_d;
            we_q       <= we_d;
            mem_pos_q  <= mem_pos_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_write_enb = we_q;
    assign mem_pos       = mem_pos_q;
    assign mem_data      = mem_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/life_pattern_loader.md
Name: life_pattern_loader

Overview:
Upstream writer for the tile memory. On a debounced load-button press it captures the preset chosen by the selector switches. It then writes that preset into every life-array tile position of the block memory through the shared memory write port. The generation controller arbitrates that port with a req/grant handshake; while loading, the controller holds off.

Parameters:
NUM_TILES, 4, number of 16-bit tiles in block memory; positions 0..NUM_TILES-1
POS_W, 2, width of tile position bus; must satisfy 2**POS_W >= NUM_TILES
TILE_W, 16, bits per tile (4x4 cells)
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required before the button level is accepted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
selector  in  4  preset select switches, asynchronous to clk
load_btn  in  1  load push-button, asynchronous, bouncing
mem_grant  in  1  controller grants the memory write port
mem_req  out  1  request for the memory write port
mem_write_enb  out  1  one-cycle write strobe per tile
mem_pos  out  POS_W  tile position being written
mem_data  out  TILE_W  tile value being written
busy  out  1  high from press acceptance until done
done  out  1  one-cycle pulse when all tiles are written

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0. Debounce counter 0. Debounced level 0. Pattern register 0.
- selector and load_btn each pass through a 2-flop synchroniser.
- Debounce: the counter increments while the synced button differs from the debounced level; otherwise it clears. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- A press is a rising edge of the debounced level. On that same cycle, the synced selector is decoded and latched. Priority is fixed, bit0 highest:
  - bit0 -> 16'h3300
  - bit1 -> 16'h33CC
  - bit2 -> 16'h0700
  - bit3 -> 16'h6186
  - none -> 16'h0000
- FSM states: IDLE, REQ, WRITE, DONE.
- IDLE:
  - Press -> REQ; busy=1, pos=0.
  - No press -> stay in IDLE.
- REQ:
  - mem_req=1.
  - mem_grant=1 -> WRITE.
- WRITE:
  - mem_req=1.
  - Each cycle with mem_grant=1: mem_write_enb=1, mem_pos=pos, mem_data=tile value, then pos increments.
  - After the write at pos=NUM_TILES-1 -> DONE.
- DONE:
  - mem_req=0, mem_write_enb=0, done=1 for exactly one cycle, busy=0 on exit.
  - Next state IDLE.
- Latency: first write occurs 1 cycle after grant is first seen high in REQ. NUM_TILES writes complete in NUM_TILES granted cycles.
- Grant drops in WRITE: no write that cycle; pos holds; mem_req stays 1; writing resumes when grant returns. There is no timeout.
- Press while busy: ignored; the pattern register is not updated.
- Selector change while busy: no effect.
- Reset mid-operation: outputs clear immediately. Partially written tiles keep their new values; there is no rollback.
- mem_pos wraps only via the FSM; it never exceeds NUM_TILES-1.
- All outputs are registered; none is combinational from inputs.

Optional Feature:
Macro LIFE_LOADER_ROTATE_EN.
- Defined: tile k receives the pattern rotated left by 4*(k mod 4) bits, giving a distinct orientation per tile.
- Undefined: every tile receives the identical latched pattern.

Decomposition:
- Shared package life_pkg:
  - TILE_W
  - POS_W
  - the four preset constants (PRESET_0..PRESET_3) and PRESET_NONE
  - FSM state enum
- Sub-module life_debounce holds the synchroniser, debounce counter and rising-edge pulse. It has parameter DEBOUNCE_CYCLES, ports clk, reset, din, level, rise.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- selector=4'b0001, clean press, mem_grant held 1 -> writes 16'h3300 at pos 0,1,2,3 on 4 consecutive cycles; done pulses once; busy low afterwards.
- selector=4'b0110 -> 16'h33CC latched (bit1 beats bit2); selector=0 -> 16'h0000 written to all 4 tiles.
- load_btn toggling every 2 cycles for 20 cycles, then stable high -> exactly one load sequence; no mem_req during bounce.
- Grant 1 for the pos 0,1 writes, dropped 3 cycles, restored -> pos 2,3 written afterwards; total 4 write strobes; no duplicate or skipped pos.
- Second press and selector change during WRITE -> ignored; data stays the first pattern; exactly one done.
- reset asserted during WRITE at pos=2 -> all outputs 0 the same cycle; IDLE after release; new press restarts from pos 0.
- With LIFE_LOADER_ROTATE_EN, pattern 16'h6186 -> tiles receive 16'h6186, 16'h1866, 16'h8661, 16'h6618 at pos 0..3.
